// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single VRAM port between the MPU and the renderer (renderer priority,
// MPU starvation guard, tagged read return). Optional build macro: VRAM_ARB_BLANK_ONLY_EN.
module vram_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int READ_LATENCY  = 2,
  parameter int MAX_REN_BURST = 8
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  mpu_req,
  input  logic                  mpu_wr,
  input  logic [1:0]            mpu_be,
  input  logic [ADDR_WIDTH-1:0] mpu_addr,
  input  logic [DATA_WIDTH-1:0] mpu_wdata,
  output logic                  mpu_ack,
  output logic                  mpu_rvalid,
  output logic [DATA_WIDTH-1:0] mpu_rdata,
  input  logic                  ren_req,
  input  logic [ADDR_WIDTH-1:0] ren_addr,
  output logic                  ren_ack,
  output logic                  ren_rvalid,
  output logic [DATA_WIDTH-1:0] ren_rdata,
  input  logic                  blank,
  output logic                  vram_en,
  output logic                  vram_rd,
  output logic                  vram_wr,
  output logic [1:0]            vram_be,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] vram_data_out,
  input  logic [DATA_WIDTH-1:0] vram_data_in
);

  localparam int LAT = READ_LATENCY;

  logic                  ren_win, mpu_win;
  logic [7:0]            starve_q, starve_d;
  logic                  vram_en_q, vram_en_d, vram_rd_q, vram_rd_d, vram_wr_q, vram_wr_d;
  logic [1:0]            vram_be_q, vram_be_d;
  logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_WIDTH-1:0] vram_data_out_q, vram_data_out_d;
  logic [LAT-1:0]        tag_v_q, tag_v_d, tag_o_q, tag_o_d;
  logic                  mpu_rvalid_q, mpu_rvalid_d, ren_rvalid_q, ren_rvalid_d;
  logic [DATA_WIDTH-1:0] mpu_rdata_q, mpu_rdata_d, ren_rdata_q, ren_rdata_d;

  // Handshake: a requester holds req and its qualifiers until ack; ack is the same-cycle
  // grant and the VRAM access issues on the closing clock edge of that cycle.
`ifdef VRAM_ARB_BLANK_ONLY_EN
  logic unused_starve;
  assign unused_starve = ^starve_q;
  assign ren_win = ren_req;
  assign mpu_win = mpu_req && blank && !ren_win;
`else
  localparam logic [7:0] MAX_BURST = 8'(MAX_REN_BURST);
  logic unused_blank;
  assign unused_blank = blank;
  assign ren_win = ren_req && !(mpu_req && (starve_q == MAX_BURST));
  assign mpu_win = mpu_req && !ren_win;
`endif

  assign mpu_ack = mpu_win;
  assign ren_ack = ren_win;

  always_comb begin
    vram_en_d       = 1'b0;
    vram_rd_d       = 1'b0;
    vram_wr_d       = 1'b0;
    vram_be_d       = 2'b00;
    vram_addr_d     = vram_addr_q;
    vram_data_out_d = vram_data_out_q;
    if (ren_win) begin
      vram_en_d       = 1'b1;
      vram_rd_d       = 1'b1;
      vram_be_d       = 2'b11;
      vram_addr_d     = ren_addr;
      vram_data_out_d = '0;
    end else if (mpu_win) begin
      vram_en_d       = 1'b1;
      vram_rd_d       = !mpu_wr;
      vram_wr_d       = mpu_wr;
      vram_be_d       = mpu_be;
      vram_addr_d     = mpu_addr;
      vram_data_out_d = mpu_wdata;
    end

`ifdef VRAM_ARB_BLANK_ONLY_EN
    starve_d = '0;
`else
    if (!mpu_req || mpu_win)                    starve_d = '0;
    else if (ren_win && starve_q < MAX_BURST)   starve_d = starve_q + 8'd1;
    else                                        starve_d = starve_q;
`endif

    // Tag owner bit: 1 = MPU, 0 = renderer. Writes never enter the pipeline.
    tag_v_d[0] = ren_win || (mpu_win && !mpu_wr);
    tag_o_d[0] = mpu_win;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_o_d[i] = tag_o_q[i-1];
    end

    mpu_rvalid_d = tag_v_q[LAT-1] && tag_o_q[LAT-1];
    ren_rvalid_d = tag_v_q[LAT-1] && !tag_o_q[LAT-1];
    mpu_rdata_d  = mpu_rvalid_d ? vram_data_in : mpu_rdata_q;
    ren_rdata_d  = ren_rvalid_d ? vram_data_in : ren_rdata_q;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      starve_q        <= '0;
      vram_en_q       <= 1'b0;
      vram_rd_q       <= 1'b0;
      vram_wr_q       <= 1'b0;
      vram_be_q       <= 2'b00;
      vram_addr_q     <= '0;
      vram_data_out_q <= '0;
      tag_v_q         <= '0;
      tag_o_q         <= '0;
      mpu_rvalid_q    <= 1'b0;
      ren_rvalid_q    <= 1'b0;
      mpu_rdata_q     <= '0;
      ren_rdata_q     <= '0;
    end else begin
      starve_q        <= starve_d;
      vram_en_q       <= vram_en_d;
      vram_rd_q       <= vram_rd_d;
      vram_wr_q       <= vram_wr_d;
      vram_be_q       <= vram_be_d;
      vram_addr_q     <= vram_addr_d;
      vram_data_out_q <= vram_data_out_d;
      tag_v_q         <= tag_v_d;
      tag_o_q         <= tag_o_d;
      mpu_rvalid_q    <= mpu_rvalid_d;
      ren_rvalid_q    <= ren_rvalid_d;
      mpu_rdata_q     <= mpu_rdata_d;
      ren_rdata_q     <= ren_rdata_d;
    end
  end

  assign vram_en       = vram_en_q;
  assign vram_rd       = vram_rd_q;
  assign vram_wr       = vram_wr_q;
  assign vram_be       = vram_be_q;
  assign vram_addr     = vram_addr_q;
  assign vram_data_out = vram_data_out_q;
  assign mpu_rvalid    = mpu_rvalid_q;
  assign mpu_rdata     = mpu_rdata_q;
  assign ren_rvalid    = ren_rvalid_q;
  assign ren_rdata     = ren_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table vectors, hand-written corner sequences and a randomized run checked
// against a transaction-level arbiter model and a read-return scoreboard.
module tb_vram_arbiter;
  localparam int AW = 16, DW = 16, LAT = 2, MAXB = 8;

  logic          clk = 1'b0;
  logic          _reset;
  logic          mpu_req, mpu_wr, ren_req, blank;
  logic [1:0]    mpu_be;
  logic [AW-1:0] mpu_addr, ren_addr;
  logic [DW-1:0] mpu_wdata;
  logic          mpu_ack, mpu_rvalid, ren_ack, ren_rvalid;
  logic [DW-1:0] mpu_rdata, ren_rdata;
  logic          vram_en, vram_rd, vram_wr;
  logic [1:0]    vram_be;
  logic [AW-1:0] vram_addr, vram_addr_dly;
  logic [DW-1:0] vram_data_out, vram_data_in;

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .MAX_REN_BURST(MAXB)) dut (
    .clk(clk), ._reset(_reset),
    .mpu_req(mpu_req), .mpu_wr(mpu_wr), .mpu_be(mpu_be), .mpu_addr(mpu_addr),
    .mpu_wdata(mpu_wdata), .mpu_ack(mpu_ack), .mpu_rvalid(mpu_rvalid), .mpu_rdata(mpu_rdata),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_ack(ren_ack), .ren_rvalid(ren_rvalid),
    .ren_rdata(ren_rdata), .blank(blank),
    .vram_en(vram_en), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_be(vram_be),
    .vram_addr(vram_addr), .vram_data_out(vram_data_out), .vram_data_in(vram_data_in)
  );

  // ---------------- clock / VRAM model ----------------
  always #5 clk = ~clk;

  // Word stored at each address; 0x0123 holds 0xBEEF.
  function automatic logic [DW-1:0] vram_word(input logic [AW-1:0] a);
    return a ^ 16'hBFCC;
  endfunction

  // Data for the address issued in cycle c is presented during cycle c+LAT-1.
  always @(posedge clk) vram_addr_dly <= vram_addr;
  assign vram_data_in = vram_word(vram_addr_dly);

  // ---------------- scoreboard / model state ----------------
  int            n_cmp = 0, n_bad = 0, cyc = 0;
  int            waited;
  logic [48:0]   exp_q[$];  // {owner_is_mpu, due_cycle[31:0], data[15:0]}
  logic          exp_en, exp_rd, exp_wr;
  logic [1:0]    exp_be;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_dout, exp_mrdata, exp_rrdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    waited = 0;
    exp_en = 0; exp_rd = 0; exp_wr = 0; exp_be = 0; exp_addr = 0; exp_dout = 0;
    exp_mrdata = 0; exp_rrdata = 0;
  endtask

  task automatic check_pins();
    logic [48:0] head;
    logic        due;
    head = '0;
    due  = 1'b0;
    chk("vram_en", vram_en, exp_en);
    chk("vram_rd", vram_rd, exp_rd);
    chk("vram_wr", vram_wr, exp_wr);
    chk("vram_be", vram_be, exp_be);
    chk("vram_addr", vram_addr, exp_addr);
    chk("vram_data_out", vram_data_out, exp_dout);
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      due  = (int'(head[47:16]) == cyc);
    end
    if (due) begin
      void'(exp_q.pop_front());
      if (head[48]) exp_mrdata = head[15:0];
      else          exp_rrdata = head[15:0];
    end
    chk("mpu_rvalid", mpu_rvalid, due && head[48]);
    chk("ren_rvalid", ren_rvalid, due && !head[48]);
    chk("mpu_rdata", mpu_rdata, exp_mrdata);
    chk("ren_rdata", ren_rdata, exp_rrdata);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic run_cycle(input logic m_req, input logic m_wr, input logic [1:0] m_be,
                           input logic [AW-1:0] m_addr, input logic [DW-1:0] m_wd,
                           input logic r_req, input logic [AW-1:0] r_addr, input logic blk);
    logic want_m, want_r, mpu_ok;
    @(negedge clk);
    cyc++;
    check_pins();
    mpu_req = m_req; mpu_wr = m_wr; mpu_be = m_be; mpu_addr = m_addr; mpu_wdata = m_wd;
    ren_req = r_req; ren_addr = r_addr; blank = blk;
    #1;
`ifdef VRAM_ARB_BLANK_ONLY_EN
    mpu_ok = m_req && blk;
    want_r = r_req;
`else
    mpu_ok = m_req;
    want_r = r_req && !(m_req && waited == MAXB);
`endif
    want_m = mpu_ok && !want_r;
    chk("mpu_ack", mpu_ack, want_m);
    chk("ren_ack", ren_ack, want_r);
`ifndef VRAM_ARB_BLANK_ONLY_EN
    if (!m_req || want_m)           waited = 0;
    else if (want_r && waited < MAXB) waited++;
`endif
    exp_en = want_r || want_m;
    exp_rd = want_r || (want_m && !m_wr);
    exp_wr = want_m && m_wr;
    exp_be = want_r ? 2'b11 : (want_m ? m_be : 2'b00);
    if (want_r) begin
      exp_addr = r_addr; exp_dout = '0;
    end else if (want_m) begin
      exp_addr = m_addr; exp_dout = m_wd;
    end
    if (exp_rd) exp_q.push_back({want_m, 32'(cyc + 1 + LAT), vram_word(want_m ? m_addr : r_addr)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 2'b00, '0, '0, 0, '0, 0);
  endtask

  task automatic reset_checks();
    chk("rst_vram_en", vram_en, 0);
    chk("rst_vram_rd", vram_rd, 0);
    chk("rst_vram_wr", vram_wr, 0);
    chk("rst_vram_be", vram_be, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_data_out", vram_data_out, 0);
    chk("rst_mpu_rvalid", mpu_rvalid, 0);
    chk("rst_ren_rvalid", ren_rvalid, 0);
    chk("rst_mpu_rdata", mpu_rdata, 0);
    chk("rst_ren_rdata", ren_rdata, 0);
    chk("rst_mpu_ack", mpu_ack, 0);
    chk("rst_ren_ack", ren_ack, 0);
  endtask

  // Asserts reset mid-cycle (called right after run_cycle) and releases it on a falling edge.
  task automatic apply_reset();
    mpu_req = 0; ren_req = 0; blank = 0;
    #2;
    _reset = 1'b0;
    #1;
    reset_checks();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    _reset = 1'b1;
  endtask

  task automatic random_phase(input int n, input int pm, input int pr);
    logic mp, rp, mw, bl;
    logic [1:0] mb;
    logic [AW-1:0] ma, ra;
    logic [DW-1:0] md;
    mp = 0; rp = 0; mw = 0; mb = 0; ma = 0; ra = 0; md = 0;
    for (int i = 0; i < n + 40; i++) begin
      if (i >= n && !mp && !rp) break;
      if (i < n && !mp && $urandom_range(0, 99) < pm) begin
        mp = 1; mw = 1'($urandom_range(0, 1)); mb = 2'($urandom_range(1, 3));
        ma = 16'($urandom); md = 16'($urandom);
      end
      if (i < n && !rp && $urandom_range(0, 99) < pr) begin
        rp = 1; ra = 16'($urandom);
      end
      bl = 1'($urandom_range(0, 1));
      run_cycle(mp, mw, mb, ma, md, rp, ra, bl);
      if (mpu_ack) mp = 0;
      if (ren_ack) rp = 0;
    end
    idle(LAT + 2);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          mreq, mwr;
    logic [1:0]    mbe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic          rreq;
    logic [AW-1:0] raddr;
    logic          e_mack, e_rack, e_rd, e_wr;
    logic [1:0]    e_be;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dout;
    logic [1:0]    e_ret;   // 0 none, 1 mpu, 2 renderer
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic got_m;
    _reset = 1'b0;
    mpu_req = 0; mpu_wr = 0; mpu_be = 0; mpu_addr = 0; mpu_wdata = 0;
    ren_req = 0; ren_addr = 0; blank = 0;
    model_clear();

    vecs[0] = '{1, 0, 2'b11, 16'h0123, 16'h0000, 0, 16'h0000, 1, 0, 1, 0, 2'b11, 16'h0123, 16'h0000, 2'd1, 16'hBEEF};
    vecs[1] = '{1, 1, 2'b01, 16'h0040, 16'hA55A, 0, 16'h0000, 1, 0, 0, 1, 2'b01, 16'h0040, 16'hA55A, 2'd0, 16'h0000};
    vecs[2] = '{0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0010, 0, 1, 1, 0, 2'b11, 16'h0010, 16'h0000, 2'd2, 16'hBFDC};
    vecs[3] = '{1, 1, 2'b11, 16'h0077, 16'h1234, 1, 16'h0055, 0, 1, 1, 0, 2'b11, 16'h0055, 16'h0000, 2'd2, 16'hBF99};
    vecs[4] = '{0, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 2'b00, 16'h0077, 16'h1234, 2'd0, 16'h0000};
    vecs[5] = '{1, 1, 2'b10, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 1, 0, 0, 1, 2'b10, 16'hFFFF, 16'hFFFF, 2'd0, 16'h0000};

    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    _reset = 1'b1;
    idle(2);

    // Table: grant decision, issued pins one cycle later, read return LAT+1 cycles after ack.
    for (int v = 0; v < 6; v++) begin
      run_cycle(vecs[v].mreq, vecs[v].mwr, vecs[v].mbe, vecs[v].maddr, vecs[v].mwd,
                vecs[v].rreq, vecs[v].raddr, 1'b1);
      chk($sformatf("vec%0d_mpu_ack", v), mpu_ack, vecs[v].e_mack);
      chk($sformatf("vec%0d_ren_ack", v), ren_ack, vecs[v].e_rack);
      got_m = mpu_ack;
      if (vecs[v].mreq && !got_m)
        run_cycle(1, vecs[v].mwr, vecs[v].mbe, vecs[v].maddr, vecs[v].mwd, 0, '0, 1'b1);
      else
        idle(1);
      chk($sformatf("vec%0d_vram_rd", v), vram_rd, vecs[v].e_rd);
      chk($sformatf("vec%0d_vram_wr", v), vram_wr, vecs[v].e_wr);
      chk($sformatf("vec%0d_vram_be", v), vram_be, vecs[v].e_be);
      chk($sformatf("vec%0d_vram_addr", v), vram_addr, vecs[v].e_addr);
      chk($sformatf("vec%0d_vram_data_out", v), vram_data_out, vecs[v].e_dout);
      idle(1);
      idle(1);
      chk($sformatf("vec%0d_mpu_rvalid", v), mpu_rvalid, vecs[v].e_ret == 2'd1);
      chk($sformatf("vec%0d_ren_rvalid", v), ren_rvalid, vecs[v].e_ret == 2'd2);
      if (vecs[v].e_ret == 2'd1) chk($sformatf("vec%0d_mpu_rdata", v), mpu_rdata, vecs[v].e_rdata);
      if (vecs[v].e_ret == 2'd2) chk($sformatf("vec%0d_ren_rdata", v), ren_rdata, vecs[v].e_rdata);
      idle(2);
    end

`ifndef VRAM_ARB_BLANK_ONLY_EN
    // Both requesters saturated: eight renderer grants, then one MPU grant, repeating.
    for (int i = 0; i < 27; i++) begin
      run_cycle(1, 0, 2'b11, 16'(16'h2000 + i), '0, 1, 16'(16'h1000 + i), 1'b0);
      chk("burst_mpu_ack", mpu_ack, (i % 9) == 8);
      chk("burst_ren_ack", ren_ack, (i % 9) != 8);
    end
    idle(LAT + 2);
`endif

    // Interleaved back-to-back reads: returns in issue order with their own data.
    run_cycle(0, 0, 2'b00, '0, '0, 1, 16'h0010, 1'b1);
    run_cycle(1, 0, 2'b11, 16'h0020, '0, 0, '0, 1'b1);
    run_cycle(0, 0, 2'b00, '0, '0, 1, 16'h0011, 1'b1);
    idle(1);
    chk("ilv0_ren_rvalid", ren_rvalid, 1);
    chk("ilv0_ren_rdata", ren_rdata, 16'hBFDC);
    idle(1);
    chk("ilv1_mpu_rvalid", mpu_rvalid, 1);
    chk("ilv1_mpu_rdata", mpu_rdata, 16'hBFEC);
    chk("ilv1_ren_rdata_hold", ren_rdata, 16'hBFDC);
    idle(1);
    chk("ilv2_ren_rvalid", ren_rvalid, 1);
    chk("ilv2_ren_rdata", ren_rdata, 16'hBFDD);
    idle(1);
    chk("ilv3_no_rvalid", mpu_rvalid | ren_rvalid, 0);
    idle(1);

    // Reset while a read tag is in flight: nothing returns after release.
    run_cycle(1, 0, 2'b11, 16'h0300, '0, 0, '0, 1'b1);
    idle(1);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_reset_no_rvalid", mpu_rvalid | ren_rvalid, 0);
    end

`ifdef VRAM_ARB_BLANK_ONLY_EN
    // MPU locked out while not in blank, granted in the first blank cycle.
    for (int i = 0; i < 50; i++) begin
      run_cycle(1, 0, 2'b11, 16'h0400, '0, 0, '0, 1'b0);
      chk("noblank_mpu_ack", mpu_ack, 0);
    end
    run_cycle(1, 0, 2'b11, 16'h0400, '0, 0, '0, 1'b1);
    chk("blank_mpu_ack", mpu_ack, 1);
    idle(LAT + 2);
`endif

    random_phase(300, 40, 50);
    random_phase(300, 90, 95);

    idle(LAT + 2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
